// File: rtl/tcb_lite_lib_copy_if.sv
// TCB-lite bus: one vld/rdy request channel plus a response returned DLY cycles after each transfer.
interface tcb_lite_if #(
    parameter int unsigned ADR = 32,
    parameter int unsigned BYT = 4,
    parameter int unsigned DLY = 1,
    parameter int unsigned MOD = 0
);
    localparam int unsigned DAT = 8 * BYT;

    typedef struct packed {
        logic           ren;
        logic           wen;
        logic [ADR-1:0] adr;
        logic [2:0]     siz;
        logic [BYT-1:0] byt;
        logic [DAT-1:0] wdt;
    } req_t;

    typedef struct packed {
        logic [DAT-1:0] rdt;
        logic           err;
    } rsp_t;

    logic vld;
    req_t req;
    logic rdy;
    rsp_t rsp;

    modport man (output vld, req, input rdy, rsp);
    modport sub (input vld, req, output rdy, rsp);
endinterface

// File: rtl/tcb_lite_lib_copy.sv
// Word copy engine: moves len BYT-wide words from src to dst over a TCB-lite manager port,
// keeping exactly one transfer outstanding and waiting DLY cycles for each response.
module tcb_lite_lib_copy #(
    parameter int unsigned LEN_W     = 16,
    parameter bit          ALIGN_CHK = 1'b1
) (
    tcb_lite_if.man            tcb,
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [tcb.ADR-1:0] src,
    input  logic [tcb.ADR-1:0] dst,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [LEN_W-1:0]   cnt
);
    localparam int unsigned ADR   = tcb.ADR;
    localparam int unsigned BYT   = tcb.BYT;
    localparam int unsigned DLY   = tcb.DLY;
    localparam int unsigned DAT   = 8 * BYT;
    localparam int unsigned DLY_W = (DLY > 1) ? $clog2(DLY) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((DLY > 0) ? DLY - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RWT  = 3'd2,
        S_WR   = 3'd3,
        S_WWT  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t           r_state;
    logic [ADR-1:0]   r_src;
    logic [ADR-1:0]   r_dst;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic             r_err;
    logic [DAT-1:0]   r_data;
    logic [DLY_W-1:0] r_dly;
    logic             r_vld;
    logic             r_ren;
    logic             r_wen;
    logic [ADR-1:0]   r_adr;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [ADR-1:0]   w_src_nxt;
    logic [ADR-1:0]   w_dst_nxt;
    logic [LEN_W-1:0] w_len_nxt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic             w_err_nxt;
    logic [DAT-1:0]   w_data_nxt;
    logic [DLY_W-1:0] w_dly_nxt;
    logic [ADR-1:0]   w_adr_nxt;
    logic             w_misaligned;
    logic             w_rd_rsp;
    logic             w_wr_rsp;

    // Response cycle of a read/write: the transfer cycle itself when DLY=0, else the last wait cycle.
    always_comb begin
        w_misaligned = ((src % ADR'(BYT)) != '0) || ((dst % ADR'(BYT)) != '0);
        w_rd_rsp     = ((r_state == S_RD)  && tcb.rdy && (DLY == 0)) ||
                       ((r_state == S_RWT) && (r_dly == DLY_LAST));
        w_wr_rsp     = ((r_state == S_WR)  && tcb.rdy && (DLY == 0)) ||
                       ((r_state == S_WWT) && (r_dly == DLY_LAST));
    end

    // Next-state and datapath update for the copy sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_data_nxt  = r_data;
        w_dly_nxt   = r_dly;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_src_nxt = src;
                    w_dst_nxt = dst;
                    w_len_nxt = len;
                    w_cnt_nxt = '0;
                    w_err_nxt = 1'b0;
                    if (ALIGN_CHK && w_misaligned) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else if (len == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD, S_RWT: begin
                if (w_rd_rsp) begin
                    if (tcb.rsp.err) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_data_nxt  = tcb.rsp.rdt;
                        w_state_nxt = S_WR;
                    end
                end else if (r_state == S_RD) begin
                    if (tcb.rdy) begin
                        w_dly_nxt   = '0;
                        w_state_nxt = S_RWT;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end else begin
                    w_dly_nxt = r_dly + DLY_W'(1);
                end
            end
            S_WR, S_WWT: begin
                if (w_wr_rsp) begin
                    if (tcb.rsp.err) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt   = r_cnt + LEN_W'(1);
                        w_state_nxt = ((r_cnt + LEN_W'(1)) < r_len) ? S_RD : S_DONE;
                    end
                end else if (r_state == S_WR) begin
                    if (tcb.rdy) begin
                        w_dly_nxt   = '0;
                        w_state_nxt = S_WWT;
                    end else begin
                        w_state_nxt = S_WR;
                    end
                end else begin
                    w_dly_nxt = r_dly + DLY_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Address of the request issued in the next cycle; wraps modulo the bus address width.
    always_comb begin
        w_adr_nxt = ((w_state_nxt == S_WR) ? w_dst_nxt : w_src_nxt) + (ADR'(w_cnt_nxt) * ADR'(BYT));
    end

    // State, datapath and registered bus/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_data  <= '0;
            r_dly   <= '0;
            r_vld   <= 1'b0;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_adr   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_data  <= w_data_nxt;
            r_dly   <= w_dly_nxt;
            r_vld   <= (w_state_nxt == S_RD) || (w_state_nxt == S_WR);
            r_ren   <= (w_state_nxt == S_RD);
            r_wen   <= (w_state_nxt == S_WR);
            r_adr   <= w_adr_nxt;
            r_busy  <= (w_state_nxt == S_RD) || (w_state_nxt == S_RWT) ||
                       (w_state_nxt == S_WR) || (w_state_nxt == S_WWT);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign tcb.vld     = r_vld;
    assign tcb.req.ren = r_ren;
    assign tcb.req.wen = r_wen;
    assign tcb.req.adr = r_adr;
    assign tcb.req.siz = 3'($clog2(BYT));
    assign tcb.req.byt = '1;
    assign tcb.req.wdt = r_data;

    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;
    assign cnt  = r_cnt;
endmodule

// File: tb/tb_tcb_lite_lib_copy.sv
// Randomized bench for tcb_lite_lib_copy: byte-addressed memory subordinate (DLY=1) plus a
// reference memory updated by word-copy arithmetic.
module tb_tcb_lite_lib_copy;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] cnt;

    always #5 clk = ~clk;

    tcb_lite_if #(.ADR(8), .BYT(4), .DLY(1), .MOD(0)) bus ();

    tcb_lite_lib_copy #(.LEN_W(16), .ALIGN_CHK(1'b1)) dut (
        .tcb   (bus),
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .src   (src),
        .dst   (dst),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .cnt   (cnt)
    );

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          err_at = 0;
    bit          bp_en = 1'b0;
    logic        pend_vld = 1'b0;
    logic        pend_err = 1'b0;
    logic [31:0] pend_rdt = 32'h0;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_adr = 8'h0;
    logic [31:0] stall_wdt = 32'h0;
    logic        stall_wen = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Memory subordinate: accepts at the edge after vld&rdy, answers one cycle later.
    always @(negedge clk) begin
        bus.rsp.rdt = pend_vld ? pend_rdt : 32'h0;
        bus.rsp.err = pend_vld & pend_err;
        pend_vld = 1'b0;
        pend_err = 1'b0;
        if (stall_prev && !rst) begin
            check_eq("stall_vld", 32'(bus.vld), 32'd1);
            check_eq("stall_adr", 32'(bus.req.adr), 32'(stall_adr));
            check_eq("stall_wdt", bus.req.wdt, stall_wdt);
            check_eq("stall_wen", 32'(bus.req.wen), 32'(stall_wen));
        end
        bus.rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.vld && bus.rdy) begin
            pend_vld = 1'b1;
            if (bus.req.wen) begin
                n_wr++;
                if (n_wr == err_at) begin
                    pend_err = 1'b1;
                end else begin
                    for (int b = 0; b < 4; b++) mem[bus.req.adr + 8'(b)] = bus.req.wdt[8*b +: 8];
                end
            end else begin
                n_rd++;
                for (int b = 0; b < 4; b++) pend_rdt[8*b +: 8] = mem[bus.req.adr + 8'(b)];
            end
        end
        stall_prev = bus.vld && !bus.rdy;
        stall_adr  = bus.req.adr;
        stall_wdt  = bus.req.wdt;
        stall_wen  = bus.req.wen;
    end

    task automatic ref_copy(input logic [7:0] s, input logic [7:0] d, input int l);
        logic [7:0] a_s;
        logic [7:0] a_d;
        for (int i = 0; i < l; i++) begin
            for (int b = 0; b < 4; b++) begin
                a_s = s + 8'(4 * i + b);
                a_d = d + 8'(4 * i + b);
                ref_mem[a_d] = ref_mem[a_s];
            end
        end
    endtask

    task automatic check_mem(input string tag);
        for (int w = 0; w < 64; w++) begin
            check_eq($sformatf("%s_mem%02h", tag, 4 * w),
                     {mem[4*w+3], mem[4*w+2], mem[4*w+1], mem[4*w]},
                     {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
        end
    endtask

    task automatic launch(input logic [7:0] s, input logic [7:0] d, input logic [15:0] l);
        @(negedge clk);
        n_rd  = 0;
        n_wr  = 0;
        start = 1'b1;
        src   = s;
        dst   = d;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        src   = $urandom;
        dst   = $urandom;
        len   = $urandom;
    endtask

    // Waits for done, counting busy cycles; then checks status and the single-cycle done pulse.
    task automatic finish_copy(input string tag, input logic exp_err, input int exp_cnt, input int exp_busy);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) cyc++;
            @(negedge clk);
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (exp_busy >= 0) check_eq({tag, "_busy_cycles"}, cyc, exp_busy);
        check_eq({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        check_eq({tag, "_cnt"}, 32'(cnt), exp_cnt);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_err_held"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        logic [7:0] s;
        logic [7:0] d;
        int         l;
        bit         found;
        bit         saw_done;
        bit         saw_vld;

        rst = 1'b1;
        start = 1'b0;
        src = 8'h0;
        dst = 8'h0;
        len = 16'h0;
        bus.rdy = 1'b1;
        bus.rsp.rdt = 32'h0;
        bus.rsp.err = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = (i < 16) ? 8'(i) : 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        check_eq("rst_vld", 32'(bus.vld), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_cnt", 32'(cnt), 32'd0);
        rst = 1'b0;

        // Basic copy with rdy=1: 4 words, 4 cycles each.
        check_eq("basic_vld_before", 32'(bus.vld), 32'd0);
        launch(8'h00, 8'h40, 16'd4);
        check_eq("basic_vld_first", 32'(bus.vld), 32'd1);
        finish_copy("basic", 1'b0, 4, 16);
        check_eq("basic_nrd", n_rd, 4);
        check_eq("basic_nwr", n_wr, 4);
        ref_copy(8'h00, 8'h40, 4);
        check_mem("basic");

        // Zero length finishes immediately without bus activity.
        launch(8'h10, 8'h80, 16'd0);
        finish_copy("zero", 1'b0, 0, 0);
        check_eq("zero_xfers", n_rd + n_wr, 0);

        // Misaligned source and destination are rejected.
        launch(8'h02, 8'h40, 16'd4);
        finish_copy("mis_src", 1'b1, 0, 0);
        check_eq("mis_src_xfers", n_rd + n_wr, 0);
        launch(8'h00, 8'h41, 16'd2);
        finish_copy("mis_dst", 1'b1, 0, 0);
        check_eq("mis_dst_xfers", n_rd + n_wr, 0);
        check_mem("mis");

        // Backpressure: random rdy, same final contents as the rdy=1 copy.
        bp_en = 1'b1;
        launch(8'h20, 8'h60, 16'd8);
        finish_copy("bp", 1'b0, 8, -1);
        bp_en = 1'b0;
        ref_copy(8'h20, 8'h60, 8);
        check_mem("bp");

        // Error response on the third write stops the copy with two words done.
        err_at = 3;
        launch(8'h40, 8'hC0, 16'd5);
        finish_copy("errrsp", 1'b1, 2, 12);
        check_eq("errrsp_nwr", n_wr, 3);
        check_eq("errrsp_nrd", n_rd, 3);
        err_at = 0;
        ref_copy(8'h40, 8'hC0, 2);
        check_mem("errrsp");

        // Reset during the first write request, then a clean copy.
        launch(8'h00, 8'hA0, 16'd4);
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (bus.vld && bus.req.wen) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("rstmid_wr_seen", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rstmid_vld", 32'(bus.vld), 32'd0);
        check_eq("rstmid_busy", 32'(busy), 32'd0);
        check_eq("rstmid_cnt", 32'(cnt), 32'd0);
        saw_done = 1'b0;
        saw_vld  = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
            if (bus.vld) saw_vld = 1'b1;
        end
        check_eq("rstmid_no_done", 32'(saw_done), 32'd0);
        check_eq("rstmid_no_vld", 32'(saw_vld), 32'd0);
        ref_copy(8'h00, 8'hA0, 1);
        launch(8'h20, 8'hA0, 16'd4);
        finish_copy("rstmid_after", 1'b0, 4, 16);
        ref_copy(8'h20, 8'hA0, 4);
        check_mem("rstmid_after");

        // Random aligned copies, including wrap-around and overlap.
        for (int t = 0; t < 12; t++) begin
            s     = {6'($urandom_range(0, 63)), 2'b00};
            d     = {6'($urandom_range(0, 63)), 2'b00};
            l     = $urandom_range(1, 6);
            bp_en = 1'($urandom_range(0, 1));
            launch(s, d, 16'(l));
            finish_copy($sformatf("rnd%0d", t), 1'b0, l, bp_en ? -1 : 4 * l);
            check_eq($sformatf("rnd%0d_nwr", t), n_wr, l);
            ref_copy(s, d, l);
            check_mem($sformatf("rnd%0d", t));
        end
        bp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
